// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding, the default reset PC, the
// instruction width, the PC increment and the word-alignment mask.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_pc_sel.sv
// Combinational next-PC select for the fetch stage.
// Priority: reset > redirect > increment > hold. Redirect targets are
// forced word-aligned.
// Ports:
//   rst_req     - reset is being applied this edge (active high)
//   redir       - redirect request
//   inc         - advance PC by one instruction
//   redir_pc    - redirect target (low two bits ignored)
//   pc          - current PC
//   pc_next_c   - PC to load at the next edge
//   pc_plus4_c  - pc + 4, wrapping modulo 2^32
module if_pc_sel
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        rst_req,
  input  logic        redir,
  input  logic        inc,
  input  logic [31:0] redir_pc,
  input  logic [31:0] pc,
  output logic [31:0] pc_next_c,
  output logic [31:0] pc_plus4_c
);

  always_comb begin
    pc_plus4_c = pc + PC_INC;
    pc_next_c  = pc;
    if (rst_req) begin
      pc_next_c = RESET_PC & ALIGN_MASK;
    end else if (redir) begin
      pc_next_c = redir_pc & ALIGN_MASK;
    end else if (inc) begin
      pc_next_c = pc_plus4_c;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a
// synchronous instruction memory and hands each instruction with its PC
// to decode over a valid/ready handshake. Execute may redirect the PC.
// Optional feature macro: IF_FETCH_CNT_EN adds a completed-handshake
// counter output fetch_cnt.
// Ports:
//   clka, rsta          - clock, synchronous active-low reset
//   imem_en, imem_addr  - memory read strobe and word address
//   imem_dout           - memory data, valid the cycle after imem_en
//   redir_valid/pc      - redirect request and target
//   id_valid/ready      - handshake to decode
//   id_instr/pc/pc4     - fetched instruction, its PC, PC + 4
//   fetch_cnt           - handshake count (IF_FETCH_CNT_EN only)
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned IMEM_AW  = 6
) (
  input  logic               clka,
  input  logic               rsta,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  input  logic               redir_valid,
  input  logic [31:0]        redir_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]        fetch_cnt
`endif
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        capture;
  logic        pc_inc;

  // Address truncates the PC; out-of-range PCs alias silently.
  assign imem_addr = pc[IMEM_AW+1:2];

  if_pc_sel #(
    .RESET_PC (RESET_PC)
  ) u_pc_sel (
    .rst_req    (!rsta),
    .redir      (redir_valid),
    .inc        (pc_inc),
    .redir_pc   (redir_pc),
    .pc         (pc),
    .pc_next_c  (pc_next),
    .pc_plus4_c (pc_plus4)
  );

  // State register.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and memory strobe; redirect overrides the normal flow.
  always_comb begin
    state_next = state;
    imem_en    = 1'b0;
    capture    = 1'b0;
    pc_inc     = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        imem_en    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        capture    = !redir_valid;
        pc_inc     = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (id_ready) begin
          imem_en    = 1'b1;
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redir_valid) begin
      state_next = REQ;
    end
  end

  // PC register; all priority resolution lives in if_pc_sel.
  always_ff @(posedge clka) begin
    pc <= pc_next;
  end

  // Decode-side output register.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
      id_pc4   <= PC_INC;
    end else if (redir_valid) begin
      id_valid <= 1'b0;
    end else if (capture) begin
      id_valid <= 1'b1;
      id_instr <= imem_dout;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
    end else if (id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

`ifdef IF_FETCH_CNT_EN
  // Handshakes coinciding with a redirect still count.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      fetch_cnt <= '0;
    end else if (id_valid && id_ready) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a synchronous instruction
// memory model whose word i holds 32'h1000_0000 + i.
module tb_if_fetch_stage;

  localparam int unsigned AW = 6;

  logic          clka;
  logic          rsta;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic          redir_valid;
  logic [31:0]   redir_pc;
  logic          id_valid;
  logic          id_ready;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic [31:0]   id_pc4;
`ifdef IF_FETCH_CNT_EN
  logic [31:0]   fetch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (AW)
  ) dut (
    .clka        (clka),
    .rsta        (rsta),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Synchronous memory: data appears the cycle after the strobe.
  always @(posedge clka) begin
    if (imem_en) imem_dout <= 32'h1000_0000 + 32'(imem_addr);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  initial begin
    rsta        = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    id_ready    = 1'b1;
    tick();
    tick();
    check_val("rst_valid", 32'(id_valid), 32'd0);
    check_val("rst_en", 32'(imem_en), 32'd0);
    check_val("rst_instr", id_instr, 32'h0);
    check_val("rst_pc", id_pc, 32'h0);
    check_val("rst_pc4", id_pc4, 32'h4);
`ifdef IF_FETCH_CNT_EN
    check_val("rst_cnt", fetch_cnt, 32'd0);
`endif

    // Reset release: REQ, RESP, then valid on the third edge.
    rsta = 1'b1;
    tick();
    check_val("e1_en", 32'(imem_en), 32'd1);
    check_val("e1_addr", 32'(imem_addr), 32'd0);
    tick();
    check_val("e2_valid", 32'(id_valid), 32'd0);
    check_val("e2_en", 32'(imem_en), 32'd0);
    tick();
    check_val("e3_valid", 32'(id_valid), 32'd1);
    check_val("e3_pc", id_pc, 32'h0);
    check_val("e3_instr", id_instr, 32'h1000_0000);
    check_val("e3_pc4", id_pc4, 32'h4);
    check_val("e3_en", 32'(imem_en), 32'd1);
    check_val("e3_addr", 32'(imem_addr), 32'd1);

    // Streaming with id_ready=1: one instruction every two edges.
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val("str_gap", 32'(id_valid), 32'd0);
      tick();
      check_val("str_valid", 32'(id_valid), 32'd1);
      check_val("str_pc", id_pc, 32'(4 * k));
      check_val("str_instr", id_instr, 32'h1000_0000 + 32'(k));
    end

    // Stall in HOLD for 5 cycles.
    id_ready = 1'b0;
    #1;
    check_val("stall_en0", 32'(imem_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("stall_valid", 32'(id_valid), 32'd1);
      check_val("stall_pc", id_pc, 32'hC);
      check_val("stall_instr", id_instr, 32'h1000_0003);
      check_val("stall_en", 32'(imem_en), 32'd0);
      check_val("stall_addr", 32'(imem_addr), 32'd4);
    end
`ifdef IF_FETCH_CNT_EN
    check_val("stall_cnt", fetch_cnt, 32'd3);
`endif
    id_ready = 1'b1;
    tick();
    check_val("acc_gap", 32'(id_valid), 32'd0);
`ifdef IF_FETCH_CNT_EN
    check_val("acc_cnt", fetch_cnt, 32'd4);
`endif

    // Redirect while in RESP: response dropped, target two edges later.
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0023;
    tick();
    redir_valid = 1'b0;
    check_val("rr_valid", 32'(id_valid), 32'd0);
    check_val("rr_en", 32'(imem_en), 32'd1);
    check_val("rr_addr", 32'(imem_addr), 32'd8);
    tick();
    check_val("rr_gap", 32'(id_valid), 32'd0);
    tick();
    check_val("rr_tvalid", 32'(id_valid), 32'd1);
    check_val("rr_tpc", id_pc, 32'h20);
    check_val("rr_tinstr", id_instr, 32'h1000_0008);
    check_val("rr_tpc4", id_pc4, 32'h24);

    // Redirect together with handshake in HOLD, target at the top of memory.
    redir_valid = 1'b1;
    redir_pc    = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    check_val("rh_valid", 32'(id_valid), 32'd0);
    check_val("rh_addr", 32'(imem_addr), 32'h3F);
`ifdef IF_FETCH_CNT_EN
    check_val("rh_cnt", fetch_cnt, 32'd5);
`endif
    tick();
    tick();
    check_val("wrap_valid", 32'(id_valid), 32'd1);
    check_val("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check_val("wrap_pc4", id_pc4, 32'h0);
    check_val("wrap_instr", id_instr, 32'h1000_003F);
    check_val("wrap_addr", 32'(imem_addr), 32'd0);
    tick();
    tick();
    check_val("wrap_npc", id_pc, 32'h0);
    check_val("wrap_ninstr", id_instr, 32'h1000_0000);

    // Reset with a redirect during RESP: reset wins.
    tick();
    rsta        = 1'b0;
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0040;
    tick();
    redir_valid = 1'b0;
    check_val("rr2_valid", 32'(id_valid), 32'd0);
    check_val("rr2_en", 32'(imem_en), 32'd0);
    check_val("rr2_addr", 32'(imem_addr), 32'd0);
    check_val("rr2_pc", id_pc, 32'h0);
    check_val("rr2_pc4", id_pc4, 32'h4);
`ifdef IF_FETCH_CNT_EN
    check_val("rr2_cnt", fetch_cnt, 32'd0);
`endif
    rsta = 1'b1;
    tick();
    tick();
    check_val("rel2_gap", 32'(id_valid), 32'd0);
    tick();
    check_val("rel2_valid", 32'(id_valid), 32'd1);
    check_val("rel2_pc", id_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction fetch stage feeding the R/I/J single-issue CPU core. Holds the program counter and issues word reads to the synchronous instruction memory. Presents each fetched instruction with its PC to the decode/execute stage over a valid/ready handshake. Accepts branch/jump redirects from execute.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- IMEM_AW, 6: instruction memory word-address width.

Ports:
- clka, input, 1: clock; all state changes on the rising edge.
- rsta, input, 1: reset, synchronous, active-low.
- imem_en, output, 1: read strobe to instruction memory.
- imem_addr, output, IMEM_AW: word address, equal to pc[IMEM_AW+1:2].
- imem_dout, input, 32: read data, valid in the cycle after imem_en=1.
- redir_valid, input, 1: redirect request from execute.
- redir_pc, input, 32: redirect target; bits [1:0] ignored (forced 0).
- id_valid, output, 1: id_instr/id_pc hold a valid instruction.
- id_ready, input, 1: downstream accepts this cycle.
- id_instr, output, 32: fetched instruction.
- id_pc, output, 32: PC of id_instr.
- id_pc4, output, 32: id_pc + 4, modulo 2^32.

## Operation
- States: IDLE, REQ, RESP, HOLD.
- Reset (rsta=0 at an edge): state=IDLE, pc=RESET_PC, id_valid=0, imem_en=0, id_instr=0, id_pc=0, id_pc4=4.
- IDLE: moves to REQ unconditionally.
- REQ: imem_en=1, imem_addr from pc; moves to RESP.
- RESP: imem_en=0; at the edge, id_instr<=imem_dout, id_pc<=pc, id_pc4<=pc+4, id_valid<=1, pc<=pc+4; moves to HOLD.
- HOLD: outputs stay stable while id_ready=0. When id_ready=1, the handshake completes. In that same cycle imem_en=1 for the new pc, id_valid drops at the edge, and the state moves to RESP. Throughput is one instruction per 2 cycles.
- Redirect has priority over everything except reset. When redir_valid=1 at an edge in any state:
  - pc<=redir_pc & ~3, id_valid<=0, state<=REQ.
  - Any read in flight or issued in the same cycle is discarded.
- Redirect together with id_valid & id_ready in HOLD: the held instruction counts as accepted, then the redirect applies.
- PC arithmetic is 32-bit unsigned with wrap-around: 32'hFFFF_FFFC + 4 = 0.
- imem_addr truncates the PC; an address beyond 2^IMEM_AW words aliases and is not flagged.

## Timing
- Reset release: first edge with rsta=1 gives IDLE→REQ. Second edge: memory samples the address. Third edge: id_valid=1.
- Redirect sampled at edge N: imem_en=1 in cycle N..N+1; id_valid=1 with id_pc=target after edge N+2.
- Accept at edge N (HOLD, id_ready=1): the next instruction is valid after edge N+1.
- Reset asserted mid-operation overrides a redirect and any in-flight read at that edge.

## Configuration
- IF_FETCH_CNT_EN defined:
  - Adds output fetch_cnt[31:0], which counts completed handshakes (id_valid & id_ready at an edge).
  - Reset value 0; wraps modulo 2^32.
  - A handshake that coincides with a redirect is counted.
- IF_FETCH_CNT_EN undefined: no port and no counter logic.

## Structure
- Shared package if_pkg holds:
  - the state enum (IDLE, REQ, RESP, HOLD);
  - the default RESET_PC;
  - the instruction width (32);
  - the PC increment (4).
- One sub-module, if_pc_sel: combinational next-PC select with priority reset > redirect > increment > hold, plus the alignment mask. Instantiated once.

## Test plan
- Reset release, memory word i = 32'h1000_0000+i, id_ready=1 → id_pc 0,4,8,... with matching instructions, one every 2 cycles; first id_valid 3 edges after release.
- id_ready=0 for 5 cycles in HOLD → id_instr/id_pc stable, imem_en=0, pc unchanged.
- redir_valid=1 with redir_pc=32'h0000_0023 while in RESP → response discarded; next id_pc=32'h0000_0020 two edges later.
- Redirect and handshake in the same HOLD cycle → held instruction consumed once (fetch_cnt +1 with IF_FETCH_CNT_EN); next id_pc is the target.
- Redirect to 32'hFFFF_FFFC, id_ready=1 → id_pc4=0, next id_pc=0.
- rsta=0 during RESP with redir_valid=1 → id_valid=0, pc=RESET_PC, fetch_cnt=0 after the edge.
